reg32_uart_tx: RTL and testbench
================================

Name: reg32_uart_tx

Overview:
- Downstream consumer of the SoC's 32-bit debug output (oREG32).
- Serialises a snapshot of that value as an ASCII line over a UART TX pin: 8 uppercase hex digits, MSB nibble first, then CR LF.
- Sends automatically whenever the value changes, or on demand.
- Gives board-level visibility of core results without a display.

Parameters:
- CLKS_PER_BIT, 434, iCLK cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- SEND_ON_CHANGE, 1, 1 = auto-trigger when iREG32 differs from the last-sent value; 0 = iSEND only.

Ports:
- iCLK  in  1  system clock
- iRST  in  1  reset, synchronous, active-high
- iREG32  in  32  value to report (connects to soc oREG32)
- iSEND  in  1  manual trigger, sampled every cycle
- oTX  out  1  UART serial line, idle high
- oBUSY  out  1  frame in progress
- oDONE  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (iRST high at a clock edge):
  - oTX=1, oBUSY=0, oDONE=0.
  - FSM goes to IDLE; char index=0; bit counters=0.
  - Last-sent register=32'h0.
  - Reset mid-frame aborts the frame: oTX=1 from the next edge, and no oDONE.
- Trigger:
  - Evaluated only in IDLE.
  - Condition: iSEND=1, or (SEND_ON_CHANGE=1 and iREG32 != last-sent).
  - iSEND and a change in the same cycle produce one frame.
  - iSEND while busy is ignored, not queued.
- On the trigger edge:
  - iREG32 is copied into both the snapshot and last-sent registers.
  - FSM goes to START; oBUSY=1 and oTX=0 from that edge, so latency is 1 cycle.
- Frame content: 10 characters, in order:
  - nibbles [31:28] down to [3:0], encoded as nibble 0-9 -> 8'h30+n and A-F -> 8'h37+n;
  - then 8'h0D, then 8'h0A.
- Character format (8N1):
  - start bit 0;
  - 8 data bits, LSB first;
  - stop bit 1.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - Characters are back-to-back, with no idle gap between one stop bit and the next start bit.
- FSM states:
  - IDLE: wait for trigger -> START.
  - START: hold oTX=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: shift out 8 bits, bit index 0..7 -> STOP.
  - STOP: hold oTX=1 for CLKS_PER_BIT cycles. Then, if char index<9, increment it and go to START; else go to IDLE with oDONE=1 for one cycle and oBUSY=0.
- Frame duration: exactly 100*CLKS_PER_BIT cycles from trigger edge to the oDONE edge.
- The snapshot is frozen for the whole frame. If iREG32 changes during a frame (iREG32 != last-sent), a new frame starts on the first IDLE cycle: one cycle after oDONE.
- Width rules:
  - bit-timer width = clog2(CLKS_PER_BIT);
  - char index 4 bits, saturating at 9;
  - bit index 3 bits.
- After reset, a non-zero iREG32 triggers immediately because last-sent is 0. A zero value does not.

Decomposition:
- Shared package holds:
  - ASCII_CR=8'h0D, ASCII_LF=8'h0A, FRAME_CHARS=10;
  - FSM state encodings (IDLE, START, DATA, STOP);
  - the nibble-to-ASCII function.
- One natural sub-module: uart_tx_byte.
  - Handles start/data/stop timing for one byte.
  - Interface: iCLK, iRST, iDATA[7:0], iVALID, oREADY, oTX.
- reg32_uart_tx keeps the trigger logic, the snapshot and last-sent registers, and the character sequencing.

Test Plan (CLKS_PER_BIT=4, SEND_ON_CHANGE=1 unless noted):
- Reset with iREG32=0 held for 200 cycles -> oTX=1, oBUSY=0, oDONE never pulses.
- iREG32=32'hDEADBEEF after reset:
  - decoded bytes are 44 45 41 44 42 45 45 46 0D 0A;
  - oDONE pulses once, exactly 400 cycles after the trigger edge.
- Bit timing on the first char of the 32'hDEADBEEF frame: oTX low for exactly 4 cycles, then bits 0,0,1,0,0,0,1,0 (0x44, LSB first), then high for 4 cycles.
- Change mid-frame: iREG32 32'h1 -> 32'h2 at cycle 150 of the frame:
  - first frame reads "00000001\r\n";
  - second frame "00000002\r\n" starts 1 cycle after oDONE.
- SEND_ON_CHANGE=0, iREG32=32'h0000000A, iSEND pulse -> "0000000A\r\n". A second iSEND pulse at cycle 50 is ignored: only one oDONE.
- iRST asserted during DATA of char 3:
  - next edge gives oTX=1, oBUSY=0, with no oDONE;
  - after release, with iREG32=32'h5, a new full frame "00000005\r\n" is sent.

Source files
------------

// File: rtl/reg32_uart_tx_pkg.sv
// Shared constants, FSM encodings and ASCII helpers for the reg32 UART
// line reporter (8 hex digits followed by CR LF).
package reg32_uart_tx_pkg;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam int         FRAME_CHARS = 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] ch;
        if (nib < 4'd10) begin
            ch = 8'h30 + {4'h0, nib};
        end else begin
            ch = 8'h37 + {4'h0, nib};
        end
        return ch;
    endfunction

    // Character idx of the line for value: nibbles MSB first, then CR, LF.
    function automatic logic [7:0] frame_char(input logic [31:0] value, input logic [3:0] idx);
        logic [7:0] ch;
        case (idx)
            4'd0:    ch = nibble_to_ascii(value[31:28]);
            4'd1:    ch = nibble_to_ascii(value[27:24]);
            4'd2:    ch = nibble_to_ascii(value[23:20]);
            4'd3:    ch = nibble_to_ascii(value[19:16]);
            4'd4:    ch = nibble_to_ascii(value[15:12]);
            4'd5:    ch = nibble_to_ascii(value[11:8]);
            4'd6:    ch = nibble_to_ascii(value[7:4]);
            4'd7:    ch = nibble_to_ascii(value[3:0]);
            4'd8:    ch = ASCII_CR;
            4'd9:    ch = ASCII_LF;
            default: ch = ASCII_LF;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. oREADY rises in the last cycle of the stop bit so a
// new byte can follow with no idle gap.
module uart_tx_byte
    import reg32_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] iDATA,
    input  logic       iVALID,
    output logic       oREADY,
    output logic       oTX
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

    logic [1:0]    state_r;
    logic [TW-1:0] timer_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          tx_r;
    logic          bit_end_s;
    logic          ready_s;
    logic          accept_s;

    // Bit boundary detection and handshake.
    always_comb begin
        bit_end_s = (timer_r == TIMER_LAST);
        ready_s   = (state_r == ST_IDLE) || ((state_r == ST_STOP) && bit_end_s);
        accept_s  = iVALID && ready_s;
    end

    // Start/data/stop bit sequencing with a registered line output.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_r   <= ST_IDLE;
            timer_r   <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
        end else if (accept_s) begin
            state_r   <= ST_START;
            timer_r   <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= iDATA;
            tx_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    timer_r <= '0;
                    tx_r    <= 1'b1;
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_r   <= ST_DATA;
                        timer_r   <= '0;
                        bit_idx_r <= 3'd0;
                        tx_r      <= shift_r[0];
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        timer_r <= '0;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        state_r <= ST_IDLE;
                        timer_r <= '0;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                    tx_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    timer_r <= '0;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

    assign oREADY = ready_s;
    assign oTX    = tx_r;

endmodule

// File: rtl/reg32_uart_tx.sv
// Reports iREG32 as an ASCII hex line over UART, on change or on iSEND.
// The first character is handed to the serialiser on the trigger edge itself.
module reg32_uart_tx
    import reg32_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 434,
    parameter bit SEND_ON_CHANGE = 1'b1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [31:0] iREG32,
    input  logic        iSEND,
    output logic        oTX,
    output logic        oBUSY,
    output logic        oDONE
);

    localparam logic [3:0] LAST_CHAR = 4'(FRAME_CHARS - 1);

    logic        busy_r;
    logic        done_r;
    logic [3:0]  char_idx_r;
    logic [31:0] snap_r;
    logic [31:0] last_r;

    logic        changed_s;
    logic        trigger_s;
    logic        advance_s;
    logic        frame_end_s;
    logic        byte_valid_s;
    logic [7:0]  byte_data_s;
    logic        byte_ready_s;

    // Trigger qualification and next-character selection.
    always_comb begin
        changed_s    = (SEND_ON_CHANGE == 1'b1) && (iREG32 != last_r);
        trigger_s    = !busy_r && (iSEND || changed_s);
        advance_s    = busy_r && byte_ready_s && (char_idx_r < LAST_CHAR);
        frame_end_s  = busy_r && byte_ready_s && (char_idx_r == LAST_CHAR);
        byte_valid_s = trigger_s || advance_s;
        if (trigger_s) begin
            byte_data_s = frame_char(iREG32, 4'd0);
        end else begin
            byte_data_s = frame_char(snap_r, char_idx_r + 4'd1);
        end
    end

    // Frame state, snapshot and last-sent value.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            char_idx_r <= 4'd0;
            snap_r     <= 32'h0;
            last_r     <= 32'h0;
        end else begin
            done_r <= frame_end_s;
            if (trigger_s) begin
                busy_r     <= 1'b1;
                char_idx_r <= 4'd0;
                snap_r     <= iREG32;
                last_r     <= iREG32;
            end else if (advance_s) begin
                char_idx_r <= char_idx_r + 4'd1;
            end else if (frame_end_s) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iDATA  (byte_data_s),
        .iVALID (byte_valid_s),
        .oREADY (byte_ready_s),
        .oTX    (oTX)
    );

    assign oBUSY = busy_r;
    assign oDONE = done_r;

endmodule

// File: tb/tb_reg32_uart_tx.sv
// Bench for reg32_uart_tx: expected line waveforms are built from the
// formatted text of each value and compared cycle by cycle.
module tb_reg32_uart_tx;

    localparam int CPB       = 4;
    localparam int CHAR_CYC  = 10 * CPB;
    localparam int FRAME_CYC = 100 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] reg_a, reg_b;
    logic        send_a, send_b;
    logic        tx_a, busy_a, done_a;
    logic        tx_b, busy_b, done_b;

    int tests_run    = 0;
    int tests_failed = 0;

    logic  rec [0:FRAME_CYC-1];
    string hexdig = "0123456789ABCDEF";

    always #5 clk = ~clk;

    reg32_uart_tx #(.CLKS_PER_BIT(CPB), .SEND_ON_CHANGE(1'b1)) dut_a (
        .iCLK(clk), .iRST(rst), .iREG32(reg_a), .iSEND(send_a),
        .oTX(tx_a), .oBUSY(busy_a), .oDONE(done_a)
    );

    reg32_uart_tx #(.CLKS_PER_BIT(CPB), .SEND_ON_CHANGE(1'b0)) dut_b (
        .iCLK(clk), .iRST(rst), .iREG32(reg_b), .iSEND(send_b),
        .oTX(tx_b), .oBUSY(busy_b), .oDONE(done_b)
    );

    function automatic logic [7:0] exp_char(input logic [31:0] v, input int i);
        logic [31:0] nib;
        if (i < 8) begin
            nib = (v >> (28 - 4 * i)) & 32'hF;
            return 8'(hexdig.getc(int'(nib)));
        end else if (i == 8) begin
            return 8'h0D;
        end else begin
            return 8'h0A;
        end
    endfunction

    // Line level k cycles after the trigger edge for value v.
    function automatic logic exp_bit(input logic [31:0] v, input int k);
        int ch, b;
        logic [7:0] c;
        ch = k / CHAR_CYC;
        b  = (k % CHAR_CYC) / CPB;
        c  = exp_char(v, ch);
        if (b == 0) return 1'b0;
        else if (b == 9) return 1'b1;
        else return c[b-1];
    endfunction

    // Called just after the negedge preceding the trigger edge.
    task automatic run_frame(input string name, input bit sel, input logic [31:0] v,
                             input int change_at, input logic [31:0] new_v, input int pulse_at);
        int wave_err, busy_err, done_err;
        logic t, b, d;
        logic [7:0] got;
        wave_err = -1; busy_err = -1; done_err = -1;
        for (int k = 0; k < FRAME_CYC; k++) begin
            @(negedge clk);
            t = sel ? tx_b : tx_a;
            b = sel ? busy_b : busy_a;
            d = sel ? done_b : done_a;
            rec[k] = t;
            if (t !== exp_bit(v, k) && wave_err < 0) wave_err = k;
            if (b !== 1'b1 && busy_err < 0) busy_err = k;
            if (d !== 1'b0 && done_err < 0) done_err = k;
            if (k == 0) begin send_a = 1'b0; send_b = 1'b0; end
            if (k == change_at) begin
                if (sel) reg_b = new_v; else reg_a = new_v;
            end
            if (k == pulse_at) begin
                if (sel) send_b = 1'b1; else send_a = 1'b1;
            end
            if (k == pulse_at + 1) begin send_a = 1'b0; send_b = 1'b0; end
        end
        tests_run++;
        if (wave_err >= 0) begin
            tests_failed++;
            $display("FAIL %s_wave: first bad cycle %0d, got %b required %b", name, wave_err,
                     rec[wave_err], exp_bit(v, wave_err));
        end
        tests_run++;
        if (busy_err >= 0) begin
            tests_failed++;
            $display("FAIL %s_busy: oBUSY low at cycle %0d, required 1", name, busy_err);
        end
        tests_run++;
        if (done_err >= 0) begin
            tests_failed++;
            $display("FAIL %s_early_done: oDONE high at cycle %0d, required 0", name, done_err);
        end
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 8; j++) got[j] = rec[i * CHAR_CYC + (j + 1) * CPB + CPB / 2];
            tests_run++;
            if (got !== exp_char(v, i)) begin
                tests_failed++;
                $display("FAIL %s_char%0d: got %h required %h", name, i, got, exp_char(v, i));
            end
        end
        @(negedge clk);
        d = sel ? done_b : done_a;
        b = sel ? busy_b : busy_a;
        tests_run++;
        if (d !== 1'b1 || b !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_end: done=%b busy=%b at cycle %0d, required done=1 busy=0",
                     name, d, b, FRAME_CYC);
        end
    endtask

    task automatic check_quiet(input string name, input bit sel, input int cycles);
        int bad;
        logic t, b, d;
        bad = -1;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            t = sel ? tx_b : tx_a;
            b = sel ? busy_b : busy_a;
            d = sel ? done_b : done_a;
            if ((t !== 1'b1 || b !== 1'b0 || d !== 1'b0) && bad < 0) bad = k;
        end
        tests_run++;
        if (bad >= 0) begin
            tests_failed++;
            $display("FAIL %s: activity at idle cycle %0d, required tx=1 busy=0 done=0", name, bad);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; reg_a = 32'h0; reg_b = 32'h0; send_a = 1'b0; send_b = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: tx=%b busy=%b done=%b required 1 0 0", tx_a, busy_a, done_a);
        end
        rst = 1'b0;
        check_quiet("reset_idle_a", 1'b0, 200);
        check_quiet("reset_idle_b", 1'b1, 10);
    endtask

    task automatic test_deadbeef();
        reg_a = 32'hDEADBEEF;
        run_frame("deadbeef", 1'b0, 32'hDEADBEEF, -1, 32'h0, -1);
        check_quiet("deadbeef_after", 1'b0, 20);
    endtask

    // First character 'D' = 0x44, fixed pattern independent of the model.
    task automatic test_bit_timing();
        int pat [10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 1};
        int bad;
        bad = -1;
        for (int i = 0; i < 40; i++) begin
            if (rec[i] !== pat[i / 4][0] && bad < 0) bad = i;
        end
        tests_run++;
        if (bad >= 0) begin
            tests_failed++;
            $display("FAIL bit_timing: cycle %0d got %b required %0d", bad, rec[bad], pat[bad / 4]);
        end
    endtask

    task automatic test_change_mid_frame();
        reg_a = 32'h1;
        run_frame("chg_first", 1'b0, 32'h1, 150, 32'h2, -1);
        run_frame("chg_second", 1'b0, 32'h2, -1, 32'h0, -1);
        check_quiet("chg_after", 1'b0, 20);
    endtask

    task automatic test_random();
        logic [31:0] v;
        for (int n = 0; n < 3; n++) begin
            v = $urandom;
            if (v == reg_a) v = v ^ 32'h1;
            reg_a = v;
            run_frame($sformatf("rand%0d", n), 1'b0, v, -1, 32'h0, -1);
        end
        check_quiet("rand_after", 1'b0, 20);
    endtask

    task automatic test_manual_send();
        reg_b  = 32'h0000000A;
        @(negedge clk);
        check_quiet("nochange_b", 1'b1, 20);
        send_b = 1'b1;
        run_frame("send", 1'b1, 32'h0000000A, -1, 32'h0, 50);
        check_quiet("send_once", 1'b1, 500);
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        bad = -1;
        reg_a = 32'h3;
        for (int k = 0; k <= 130; k++) begin
            @(negedge clk);
            if (done_a !== 1'b0 && bad < 0) bad = k;
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_abort: tx=%b busy=%b done=%b required 1 0 0", tx_a, busy_a, done_a);
        end
        repeat (3) begin
            @(negedge clk);
            if (done_a !== 1'b0 && bad < 0) bad = 999;
        end
        tests_run++;
        if (bad >= 0) begin
            tests_failed++;
            $display("FAIL rst_no_done: oDONE seen at %0d, required none", bad);
        end
        reg_a = 32'h5;
        rst   = 1'b0;
        run_frame("after_rst", 1'b0, 32'h5, -1, 32'h0, -1);
        check_quiet("after_rst_idle", 1'b0, 20);
    endtask

    initial begin
        test_reset();
        test_deadbeef();
        test_bit_timing();
        test_change_mid_frame();
        test_random();
        test_manual_send();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
